// File: rtl/out_drain_ctrl_pkg.sv
// tdnn_ctrl_pkg: shared state encoding and address-layout selectors for the output drain
package tdnn_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, START, DRAIN} drain_st_t;
  localparam logic MODE_CH = 1'b0;
  localparam logic MODE_PIX = 1'b1;
endpackage

// File: rtl/out_drain_ctrl_if.sv
// out_drain_ctrl_if: MAC-side pass control plus output-buffer address handshake
interface out_drain_ctrl_if #(
  parameter int CW = 4,
  parameter int PW = 10,
  parameter int AW = 12
);
  logic s_init, k_fin, mode, out_ready, out_valid, update, busy, active, err_ovf;
  logic [CW-1:0] od;
  logic [PW-1:0] os;
  logic [AW-1:0] oa;
  modport master (
    output s_init, k_fin, od, os, mode, out_ready,
    input out_valid, oa, update, busy, active, err_ovf
  );
  modport slave (
    input s_init, k_fin, od, os, mode, out_ready,
    output out_valid, oa, update, busy, active, err_ovf
  );
endinterface

// File: rtl/out_drain_ctrl_wrap_cnt.sv
// wrap_cnt: enable-gated counter with clear, wrapping to 0 after reaching wrap_i
module wrap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] wrap_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == wrap_i;
  assign cnt_d = clr_i ? '0 : en_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
  assign cnt_o = cnt_q;
  // count register; clear wins over enable
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/out_drain_ctrl.sv
// out_drain_ctrl: queues finished passes and streams one output address per channel per pass
module out_drain_ctrl
  import tdnn_ctrl_pkg::*;
#(
  parameter int CW = 4,
  parameter int PW = 10,
  parameter int AW = 12,
  parameter int PEND_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  out_drain_ctrl_if.slave bus
);
  localparam int PNW = $clog2(PEND_DEPTH + 1);
  localparam int FW = CW + PW + 2;
  drain_st_t state_q, state_d;
  logic [PNW-1:0] pend_q, pend_d;
  logic busy_q, busy_d, err_q, err_d, sinit_q, sinit_d;
  logic [AW-1:0] oa_q, oa_d;
  logic [CW-1:0] ct, ct_n;
  logic [PW-1:0] wi, wi_n;
  logic ct_last, wi_last, ct_clr, fire, fin, go, wi_clr;
  logic [FW-1:0] ch_a, px_a;
  assign go = (pend_q != '0) | bus.k_fin;
  assign fire = (state_q == DRAIN) & bus.out_ready;
  assign fin = fire & ct_last;
  assign ct_clr = state_q == START;
  assign wi_clr = ((state_q == IDLE) & bus.s_init) | (fin & (sinit_q | bus.s_init));
  wrap_cnt #(.W(CW)) u_ct (
    .clk(clk), .rst(rst), .en_i(fire), .clr_i(ct_clr), .wrap_i(bus.od),
    .cnt_o(ct), .last_o(ct_last)
  );
  wrap_cnt #(.W(PW)) u_wi (
    .clk(clk), .rst(rst), .en_i(fin), .clr_i(wi_clr), .wrap_i(bus.os - PW'(1)),
    .cnt_o(wi), .last_o(wi_last)
  );
  // next counter values feed the address register so oa moves in lockstep with ct/wi
  always_comb begin
    ct_n = ct_clr ? '0 : fire ? (ct_last ? '0 : ct + 1'b1) : ct;
    wi_n = wi_clr ? '0 : fin ? (wi_last ? '0 : wi + 1'b1) : wi;
    ch_a = FW'(ct_n) * FW'(bus.os) + FW'(wi_n);
    px_a = FW'(wi_n) * (FW'(bus.od) + FW'(1)) + FW'(ct_n);
    oa_d = AW'(bus.mode == MODE_CH ? ch_a : px_a);
  end
  // next state, pass queue, deferred sample restart and overflow flag
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = START;
      START:   state_d = DRAIN;
      DRAIN:   if (fin) state_d = go ? START : IDLE;
      default: state_d = IDLE;
    endcase
    pend_d = pend_q + PNW'(bus.k_fin & ~busy_q) - PNW'(state_d == START);
    busy_d = pend_d == PNW'(PEND_DEPTH);
    sinit_d = (state_q != IDLE) & (sinit_q | bus.s_init) & ~fin;
    err_d = err_q | (bus.k_fin & busy_q);
  end
  // state and control registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      sinit_q <= 1'b0;
      oa_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      err_q <= err_d;
      sinit_q <= sinit_d;
      oa_q <= oa_d;
    end
  assign bus.out_valid = state_q == DRAIN;
  assign bus.update = state_q == START;
  assign bus.active = state_q != IDLE;
  assign bus.busy = busy_q;
  assign bus.err_ovf = err_q;
  assign bus.oa = oa_q;
endmodule

// File: tb/tb_out_drain_ctrl.sv
// tb_out_drain_ctrl: directed checks of drain timing, backpressure, queueing, layouts, s_init and reset
module tb_out_drain_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int miss = 0;
  int acc = 0;
  int acc0;
  out_drain_ctrl_if #(.CW(4), .PW(10), .AW(12)) bus ();
  out_drain_ctrl #(.CW(4), .PW(10), .AW(12), .PEND_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.out_valid & bus.out_ready) acc <= acc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  initial begin
    bus.s_init = 0; bus.k_fin = 0; bus.mode = 0; bus.out_ready = 1;
    bus.od = 4'd3; bus.os = 10'd8;
    step(); step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_oa", bus.oa, 0);
    chk("rst_update", bus.update, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_err", bus.err_ovf, 0);
    rst = 0;
    step();
    // single channel-major drain
    bus.k_fin = 1; step(); bus.k_fin = 0;
    chk("t1_update", bus.update, 1);
    chk("t1_novalid", bus.out_valid, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_oa", bus.oa, 32'(c * 8));
    end
    step();
    chk("t1_idle", bus.active, 0);
    chk("t1_wi1", bus.oa, 1);
    // backpressure on the second beat
    bus.od = 4'd2; acc0 = acc;
    bus.k_fin = 1; step(); bus.k_fin = 0;
    chk("t2_update", bus.update, 1);
    step(); chk("t2_oa0", bus.oa, 1);
    step(); chk("t2_oa1", bus.oa, 9);
    bus.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_hold", bus.oa, 9);
      chk("t2_hold_v", bus.out_valid, 1);
    end
    bus.out_ready = 1;
    step(); chk("t2_oa2", bus.oa, 17);
    step(); chk("t2_idle", bus.active, 0);
    chk("t2_beats", 32'(acc - acc0), 3);
    chk("t2_wi2", bus.oa, 2);
    // queue overflow during a stalled drain
    bus.k_fin = 1; step(); bus.out_ready = 0; bus.k_fin = 0;
    step(); chk("t3_drain", bus.out_valid, 1);
    bus.k_fin = 1; step();
    chk("t3_busy1", bus.busy, 0);
    step();
    chk("t3_busy2", bus.busy, 1);
    chk("t3_err0", bus.err_ovf, 0);
    step(); bus.k_fin = 0;
    chk("t3_err1", bus.err_ovf, 1);
    chk("t3_busy3", bus.busy, 1);
    chk("t3_oa", bus.oa, 2);
    bus.out_ready = 1;
    step(); chk("t3_a1", bus.oa, 10);
    step(); chk("t3_a2", bus.oa, 18);
    for (int d = 3; d < 5; d++) begin
      step();
      chk("t3_bubble", bus.update, 1);
      chk("t3_bub_v", bus.out_valid, 0);
      chk("t3_busy_low", bus.busy, 0);
      for (int c = 0; c < 3; c++) begin
        step();
        chk("t3_oa", bus.oa, 32'(c * 8 + d));
      end
    end
    step(); chk("t3_idle", bus.active, 0);
    chk("t3_wi5", bus.oa, 5);
    // pixel-major with wi wrap at os=3
    bus.mode = 1; bus.od = 4'd3; bus.os = 10'd3;
    bus.s_init = 1; step(); bus.s_init = 0;
    chk("t4_init", bus.oa, 0);
    for (int d = 0; d < 4; d++) begin
      bus.k_fin = 1; step(); bus.k_fin = 0;
      chk("t4_update", bus.update, 1);
      for (int c = 0; c < 4; c++) begin
        step();
        chk("t4_oa", bus.oa, 32'((d % 3) * 4 + c));
      end
      step(); chk("t4_idle", bus.active, 0);
    end
    chk("t4_err_sticky", bus.err_ovf, 1);
    // single-beat drains to reach wi=5, then s_init mid-drain
    bus.mode = 0; bus.od = 4'd0; bus.os = 10'd8;
    bus.s_init = 1; step(); bus.s_init = 0;
    for (int d = 0; d < 5; d++) begin
      bus.k_fin = 1; step(); bus.k_fin = 0;
      step(); chk("t5_single", bus.oa, 32'(d));
      step(); chk("t5_single_idle", bus.active, 0);
    end
    bus.od = 4'd2;
    bus.k_fin = 1; step(); bus.k_fin = 0;
    step(); chk("t5_oa0", bus.oa, 5);
    bus.s_init = 1; step(); bus.s_init = 0;
    chk("t5_oa1", bus.oa, 13);
    step(); chk("t5_oa2", bus.oa, 21);
    step(); chk("t5_idle", bus.active, 0);
    chk("t5_wi0", bus.oa, 0);
    bus.k_fin = 1; step(); bus.k_fin = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_next", bus.oa, 32'(c * 8));
    end
    step();
    // asynchronous reset in the middle of a stalled drain
    bus.out_ready = 0;
    bus.k_fin = 1; step(); step(); step(); bus.k_fin = 0;
    chk("t6_busy", bus.busy, 1);
    chk("t6_valid", bus.out_valid, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_err", bus.err_ovf, 0);
    chk("t6_rst_active", bus.active, 0);
    step(); rst = 0; bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_update", bus.update, 0);
      chk("t6_no_active", bus.active, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
